fb_slave_tx_framer: RTL and testbench

Transmit-side framer for a FreeDM bus slave node, the counterpart of the slave receive counters on the same link.
- On a start request, drives a nibble stream onto the MII-style transmit interface in this order: preamble, SoC nibble, slave data read byte-wise from the TX RAM, then a 2-nibble slave CRC.
- Maintains its own nibble and byte counters and the TX RAM read address.
- Sits between the slave TX RAM and the PHY transmit pins, clocked by MTxClk.

---
 rtl/fb_slave_tx_framer_pkg.sv | 20 ++
 rtl/fb_slave_tx_framer_if.sv | 26 ++
 rtl/fb_slave_tx_framer_crc8_nib.sv | 19 +
 rtl/fb_slave_tx_framer.sv | 201 ++++++++++++++++++++
 tb/tb_fb_slave_tx_framer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fb_slave_tx_framer_pkg.sv
// Shared types and constants for the FreeDM slave transmit framer.
// State encoding, fixed nibble values and CRC-8 parameters.
package fb_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SOC,
      ST_DATA_LO,
      ST_DATA_HI,
      ST_CRC,
      ST_GAP
   } tx_state_e;

   localparam logic [3:0] PREAMBLE_NIB = 4'h5;
   localparam logic [3:0] SOC_NIB      = 4'hD;
   localparam logic [7:0] CRC8_POLY    = 8'h07;
   localparam logic [7:0] CRC8_INIT    = 8'h00;

endpackage

// File: rtl/fb_slave_tx_framer_if.sv
// Transmit-side bundle: start/abort control, TX RAM read port and PHY nibble pins.
// master = frame requester / RAM / PHY side, slave = the framer.
interface fb_slave_tx_framer_if;
   logic        TxStart;
   logic        TxAbort;
   logic [7:0]  TxByteCnt;
   logic [7:0]  TxRamData;
   logic        TxRamRd;
   logic [7:0]  TxRamAddr;
   logic [3:0]  MTxD;
   logic        MTxEn;
   logic        TxBusy;
   logic        TxDone;
   logic        TxAborted;
   logic [15:0] TotalNibCnt;

   modport master (
      output TxStart, TxAbort, TxByteCnt, TxRamData,
      input  TxRamRd, TxRamAddr, MTxD, MTxEn, TxBusy, TxDone, TxAborted, TotalNibCnt
   );

   modport slave (
      input  TxStart, TxAbort, TxByteCnt, TxRamData,
      output TxRamRd, TxRamAddr, MTxD, MTxEn, TxBusy, TxDone, TxAborted, TotalNibCnt
   );
endinterface

// File: rtl/fb_slave_tx_framer_crc8_nib.sv
// Combinational CRC-8 step over one nibble, MSB first.
module fb_crc8_nib
   import fb_tx_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [3:0] nib_in,
   output logic [7:0] crc_out
);
   logic [7:0] crc_w;

   always_comb begin
      crc_w = crc_in;
      for (int i = 3; i >= 0; i--) begin
         if (crc_w[7] ^ nib_in[i]) crc_w = {crc_w[6:0], 1'b0} ^ CRC8_POLY;
         else                      crc_w = {crc_w[6:0], 1'b0};
      end
      crc_out = crc_w;
   end
endmodule

// File: rtl/fb_slave_tx_framer.sv
// FreeDM slave transmit framer: preamble, SoC, RAM data nibbles, CRC-8, then gap.
// state        | meaning
// ST_IDLE      | waiting for TxStart
// ST_PREAMBLE  | sending 0x5 nibbles, last one issues the first RAM read
// ST_SOC       | sending 0xD, first data byte captured at the end
// ST_DATA_LO   | low nibble of held byte, prefetch of next byte
// ST_DATA_HI   | high nibble of held byte, next byte captured
// ST_CRC       | two CRC nibbles, high first
// ST_GAP       | inter-frame idle, still busy
module fb_slave_tx_framer
   import fb_tx_pkg::*;
#(
   parameter int unsigned PREAMBLE_NIBS = 7,
   parameter int unsigned IFG_NIBS      = 4
)(
   input  logic                 MTxClk,
   input  logic                 Reset,
   fb_slave_tx_framer_if.slave  bus
);
   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_NIBS - 1);
   localparam logic [3:0] IFG_LAST = 4'(IFG_NIBS - 1);

   tx_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  bytes_q, bytes_d;
   logic [7:0]  held_q, held_d;
   logic [7:0]  crc_q, crc_d;
   logic        ram_rd_q, ram_rd_d;
   logic [7:0]  ram_addr_q, ram_addr_d;
   logic [3:0]  mtxd_q, mtxd_d;
   logic        mtxen_q, mtxen_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic [15:0] tot_q, tot_d;
   logic [3:0]  crc_nib;
   logic [7:0]  crc_nxt;

   // Data nibble about to go out: a fresh byte's low half comes straight from the RAM bus.
   assign crc_nib = (state_q == ST_DATA_LO) ? held_q[7:4] : bus.TxRamData[3:0];

   fb_crc8_nib u_crc (
      .crc_in  (crc_q),
      .nib_in  (crc_nib),
      .crc_out (crc_nxt)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bytes_d    = bytes_q;
      held_d     = held_q;
      crc_d      = crc_q;
      ram_rd_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      mtxd_d     = mtxd_q;
      mtxen_d    = mtxen_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      tot_d      = (mtxen_q && tot_q != 16'hFFFF) ? tot_q + 16'd1 : tot_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.TxStart) begin
               state_d    = ST_PREAMBLE;
               cnt_d      = PRE_LAST;
               bytes_d    = bus.TxByteCnt;
               ram_addr_d = 8'd0;
               tot_d      = 16'd0;
               crc_d      = CRC8_INIT;
               mtxd_d     = PREAMBLE_NIB;
               mtxen_d    = 1'b1;
               busy_d     = 1'b1;
            end
         end
         ST_PREAMBLE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_SOC;
               mtxd_d  = SOC_NIB;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_SOC: begin
            held_d = bus.TxRamData;
            if (bytes_q != 8'd0) begin
               state_d = ST_DATA_LO;
               mtxd_d  = bus.TxRamData[3:0];
               crc_d   = crc_nxt;
               if (bytes_q > 8'd1) begin
                  ram_rd_d   = 1'b1;
                  ram_addr_d = ram_addr_q + 8'd1;
               end
            end else begin
               state_d = ST_CRC;
               mtxd_d  = crc_q[7:4];
               cnt_d   = 4'd0;
            end
         end
         ST_DATA_LO: begin
            state_d = ST_DATA_HI;
            mtxd_d  = held_q[7:4];
            crc_d   = crc_nxt;
         end
         ST_DATA_HI: begin
            held_d  = bus.TxRamData;
            bytes_d = bytes_q - 8'd1;
            if (bytes_q != 8'd1) begin
               state_d = ST_DATA_LO;
               mtxd_d  = bus.TxRamData[3:0];
               crc_d   = crc_nxt;
               if (bytes_q > 8'd2) begin
                  ram_rd_d   = 1'b1;
                  ram_addr_d = ram_addr_q + 8'd1;
               end
            end else begin
               state_d = ST_CRC;
               mtxd_d  = crc_q[7:4];
               cnt_d   = 4'd0;
            end
         end
         ST_CRC: begin
            if (cnt_q == 4'd0) begin
               cnt_d  = 4'd1;
               mtxd_d = crc_q[3:0];
               done_d = 1'b1;
            end else begin
               state_d = ST_GAP;
               mtxd_d  = 4'd0;
               mtxen_d = 1'b0;
               cnt_d   = IFG_LAST;
            end
         end
         ST_GAP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // First byte is fetched during the last preamble nibble so SoC can capture it.
      if (state_d == ST_PREAMBLE && cnt_d == 4'd0 && bytes_d != 8'd0)
         ram_rd_d = 1'b1;

      if (bus.TxAbort && (state_q inside {ST_PREAMBLE, ST_SOC, ST_DATA_LO, ST_DATA_HI, ST_CRC})) begin
         state_d   = ST_GAP;
         cnt_d     = IFG_LAST;
         mtxd_d    = 4'd0;
         mtxen_d   = 1'b0;
         ram_rd_d  = 1'b0;
         done_d    = 1'b0;
         aborted_d = 1'b1;
      end
   end

   always_ff @(posedge MTxClk) begin
      if (!Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         bytes_q    <= 8'd0;
         held_q     <= 8'd0;
         crc_q      <= CRC8_INIT;
         ram_rd_q   <= 1'b0;
         ram_addr_q <= 8'd0;
         mtxd_q     <= 4'd0;
         mtxen_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         tot_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bytes_q    <= bytes_d;
         held_q     <= held_d;
         crc_q      <= crc_d;
         ram_rd_q   <= ram_rd_d;
         ram_addr_q <= ram_addr_d;
         mtxd_q     <= mtxd_d;
         mtxen_q    <= mtxen_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         tot_q      <= tot_d;
      end
   end

   assign bus.TxRamRd     = ram_rd_q;
   assign bus.TxRamAddr   = ram_addr_q;
   assign bus.MTxD        = mtxd_q;
   assign bus.MTxEn       = mtxen_q;
   assign bus.TxBusy      = busy_q;
   assign bus.TxDone      = done_q;
   assign bus.TxAborted   = aborted_q;
   assign bus.TotalNibCnt = tot_q;
endmodule

// File: tb/tb_fb_slave_tx_framer.sv
// Self-checking bench for fb_slave_tx_framer: nibble scoreboard plus per-frame summary checks.
module tb_fb_slave_tx_framer;
   localparam int PRE = 7;
   localparam int IFG = 4;

   logic clk = 1'b0;
   logic rst_b;
   logic [7:0] ram [256];
   logic [3:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int nib_cnt = 0;
   int done_cnt = 0;
   int abort_cnt = 0;
   int rd_cnt = 0;
   int frame_base = 0;
   int exp_len = 0;

   fb_slave_tx_framer_if tx_if ();

   fb_slave_tx_framer #(.PREAMBLE_NIBS(PRE), .IFG_NIBS(IFG)) dut (
      .MTxClk (clk),
      .Reset  (rst_b),
      .bus    (tx_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // TX RAM model: data valid the cycle after a read strobe
   always @(posedge clk)
      if (tx_if.TxRamRd) tx_if.TxRamData <= ram[tx_if.TxRamAddr];

   always @(negedge clk) begin
      if (tx_if.MTxEn === 1'b1) begin
         logic [31:0] e;
         nib_cnt++;
         e = 32'hFFFF_FFFF;
         if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
         check("nibble", 32'(tx_if.MTxD), e);
      end
      if (tx_if.TxDone === 1'b1) begin
         done_cnt++;
         check("done_pos", 32'(nib_cnt - frame_base), 32'(exp_len));
      end
      if (tx_if.TxAborted === 1'b1) abort_cnt++;
      if (tx_if.TxRamRd === 1'b1) rd_cnt++;
   end

   // Expected nibble stream; CRC by long division of the data bits augmented with 8 zeros.
   task automatic build_exp(input int n, input int limit);
      logic [3:0] nibs[$];
      bit bits[$];
      logic [7:0] b;
      logic [7:0] r;
      logic top;
      for (int i = 0; i < PRE; i++) nibs.push_back(4'h5);
      nibs.push_back(4'hD);
      for (int k = 0; k < n; k++) begin
         b = ram[k];
         nibs.push_back(b[3:0]);
         nibs.push_back(b[7:4]);
         for (int j = 3; j >= 0; j--) bits.push_back(b[j]);
         for (int j = 7; j >= 4; j--) bits.push_back(b[j]);
      end
      for (int j = 0; j < 8; j++) bits.push_back(1'b0);
      r = 8'h00;
      foreach (bits[i]) begin
         top = r[7];
         r = {r[6:0], bits[i]};
         if (top) r = r ^ 8'h07;
      end
      nibs.push_back(r[7:4]);
      nibs.push_back(r[3:0]);
      for (int i = 0; i < limit; i++) exp_q.push_back(nibs[i]);
   endtask

   task automatic run_frame(input int n, input int start_inj, input int abort_cyc, input bit abort_at_start);
      int len, limit, rd_exp, busy_cycles, cyc, base_rd, base_done, base_abt;
      bit aborted;
      len = PRE + 1 + 2 * n + 2;
      aborted = (abort_cyc != 0) && (abort_cyc <= len);
      limit = aborted ? abort_cyc : len;
      build_exp(n, limit);
      rd_exp = 0;
      if (n > 0 && PRE <= limit) rd_exp = 1;
      for (int k = 0; k < n - 1; k++)
         if (PRE + 2 + 2 * k <= limit) rd_exp++;
      exp_len = aborted ? 0 : len;
      frame_base = nib_cnt;
      base_rd = rd_cnt;
      base_done = done_cnt;
      base_abt = abort_cnt;
      tx_if.TxByteCnt = 8'(n);
      tx_if.TxStart = 1'b1;
      tx_if.TxAbort = abort_at_start;
      @(posedge clk); #1;
      tx_if.TxStart = 1'b0;
      tx_if.TxAbort = 1'b0;
      cyc = 1;
      busy_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!tx_if.TxBusy) break;
         busy_cycles++;
         tx_if.TxStart = (cyc == start_inj);
         tx_if.TxAbort = (cyc == abort_cyc);
         @(posedge clk); #1;
         cyc++;
      end
      tx_if.TxStart = 1'b0;
      tx_if.TxAbort = 1'b0;
      check("busy_timeout", 32'(tx_if.TxBusy), 32'd0);
      check("nib_count", 32'(nib_cnt - frame_base), 32'(limit));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(done_cnt - base_done), aborted ? 32'd0 : 32'd1);
      check("abort_count", 32'(abort_cnt - base_abt), aborted ? 32'd1 : 32'd0);
      check("ram_reads", 32'(rd_cnt - base_rd), 32'(rd_exp));
      check("ram_addr", 32'(tx_if.TxRamAddr), (rd_exp == 0) ? 32'd0 : 32'(rd_exp - 1));
      check("total_nib", 32'(tx_if.TotalNibCnt), 32'(limit));
      check("busy_len", 32'(busy_cycles), 32'(limit + IFG));
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_b = 1'b0;
      tx_if.TxStart = 1'b0;
      tx_if.TxAbort = 1'b0;
      tx_if.TxByteCnt = 8'd0;
      tx_if.TxRamData = 8'd0;
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      ram[0] = 8'hA3;
      ram[1] = 8'h5C;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mtxen", 32'(tx_if.MTxEn), 32'd0);
      check("rst_mtxd", 32'(tx_if.MTxD), 32'd0);
      check("rst_busy", 32'(tx_if.TxBusy), 32'd0);
      check("rst_rd", 32'(tx_if.TxRamRd), 32'd0);
      check("rst_addr", 32'(tx_if.TxRamAddr), 32'd0);
      check("rst_total", 32'(tx_if.TotalNibCnt), 32'd0);
      check("rst_done", 32'(tx_if.TxDone), 32'd0);
      check("rst_aborted", 32'(tx_if.TxAborted), 32'd0);
      rst_b = 1'b1;
      @(posedge clk); #1;

      run_frame(2, 0, 0, 1'b0);
      run_frame(0, 0, 0, 1'b1);
      run_frame(2, 10, 0, 1'b0);
      run_frame(4, 0, 11, 1'b0);

      // reset asserted during the first CRC nibble
      build_exp(1, PRE + 1 + 2 + 1);
      exp_len = 0;
      base = nib_cnt;
      frame_base = nib_cnt;
      tx_if.TxByteCnt = 8'd1;
      tx_if.TxStart = 1'b1;
      @(posedge clk); #1;
      tx_if.TxStart = 1'b0;
      repeat (PRE + 3) @(posedge clk);
      #1;
      rst_b = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_mtxen", 32'(tx_if.MTxEn), 32'd0);
      check("mid_rst_total", 32'(tx_if.TotalNibCnt), 32'd0);
      check("mid_rst_busy", 32'(tx_if.TxBusy), 32'd0);
      rst_b = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_nibs", 32'(nib_cnt - base), 32'(PRE + 4));
      check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
      exp_q.delete();

      run_frame(3, 0, PRE + 1 + 6 + 2 + 2, 1'b0);

      for (int i = 0; i < 256; i++) ram[i] = 8'(i);
      run_frame(255, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
